// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit that owns the HI/LO registers.
// Latency: MUL/DIV N+1 unstalled edges (N = DATA_WIDTH/BITS_PER_CYCLE); MTHI/MTLO take one edge.
// Backpressure: stall freezes everything; start is ignored while busy; cancel aborts an in-flight op.
// Ports: clk, rst (sync, active-high); stall, cancel; start/op/rs/rt issue a request;
//        busy, done (1-cycle pulse), div_by_zero (valid with done); hi, lo registers.
module mul_div_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  cancel,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] rs,
  input  logic [DATA_WIDTH-1:0] rt,
  output logic                  busy,
  output logic                  done,
  output logic                  div_by_zero,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);
  localparam int W  = DATA_WIDTH;
  localparam int N  = W / BITS_PER_CYCLE;
  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIXUP} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  // acc: upper product half (multiply) or partial remainder (divide)
  // low: multiplier shifting out / product low half, or dividend shifting out / quotient
  logic [W:0]      acc;
  logic [W-1:0]    low;
  logic [W-1:0]    opnd;     // multiplicand or divisor (magnitude)
  logic            is_div;
  logic            neg_lo;   // negate product (mul) or quotient (div)
  logic            neg_hi;   // negate remainder (div)
  logic            dbz;

  logic            accept, op_arith, sgn;
  logic [W-1:0]    rs_abs, rt_abs;
  logic [W:0]      acc_step, sum;
  logic [W-1:0]    low_step;
  logic [2*W-1:0]  prod;
  logic [W-1:0]    res_hi, res_lo;

  assign busy     = (state != IDLE);
  assign accept   = (state == IDLE) && start && !stall && !cancel;
  assign op_arith = !op[2];
  assign sgn      = !op[0];
  assign rs_abs   = (sgn && rs[W-1]) ? -rs : rs;
  assign rt_abs   = (sgn && rt[W-1]) ? -rt : rt;

  // One iteration retires BITS_PER_CYCLE single-bit shift-add or restoring-divide steps.
  always_comb begin
    acc_step = acc;
    low_step = low;
    sum      = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (is_div) begin
        acc_step = {acc_step[W-1:0], low_step[W-1]};
        low_step = {low_step[W-2:0], 1'b0};
        if (acc_step >= {1'b0, opnd}) begin
          acc_step    = acc_step - {1'b0, opnd};
          low_step[0] = 1'b1;
        end
      end else begin
        sum      = {1'b0, acc_step[W-1:0]} + (low_step[0] ? {1'b0, opnd} : {(W+1){1'b0}});
        low_step = {sum[0], low_step[W-1:1]};
        acc_step = {1'b0, sum[W:1]};
      end
    end
  end

  // Sign correction. A zero divisor is latched with raw rs and no sign flags, so the
  // unsigned divide yields quotient all-ones and remainder rs untouched.
  always_comb begin
    prod = {acc[W-1:0], low};
    if (neg_lo) prod = -prod;
    if (is_div) begin
      res_lo = neg_lo ? -low : low;
      res_hi = neg_hi ? -acc[W-1:0] : acc[W-1:0];
    end else begin
      res_hi = prod[2*W-1:W];
      res_lo = prod[W-1:0];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && op_arith) state_nxt = CALC;
      CALC:    if (cancel) state_nxt = IDLE;
               else if (!stall && cnt == CW'(N-1)) state_nxt = FIXUP;
      FIXUP:   if (cancel || !stall) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      acc         <= '0;
      low         <= '0;
      opnd        <= '0;
      is_div      <= 1'b0;
      neg_lo      <= 1'b0;
      neg_hi      <= 1'b0;
      dbz         <= 1'b0;
    end else begin
      state       <= state_nxt;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      if (accept) begin
        if (op_arith) begin
          cnt    <= '0;
          acc    <= '0;
          is_div <= op[1];
          opnd   <= rt_abs;
          if (op[1] && rt == '0) begin
            low    <= rs;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            dbz    <= 1'b1;
          end else begin
            low    <= rs_abs;
            neg_lo <= sgn && (rs[W-1] ^ rt[W-1]);
            neg_hi <= sgn && rs[W-1];
            dbz    <= 1'b0;
          end
        end else if (op == 3'b100) begin
          hi <= rs;
        end else if (op == 3'b101) begin
          lo <= rs;
        end
      end else if (state == CALC && !stall && !cancel) begin
        acc <= acc_step;
        low <= low_step;
        cnt <= cnt + CW'(1);
      end else if (state == FIXUP && !stall && !cancel) begin
        hi          <= res_hi;
        lo          <= res_lo;
        done        <= 1'b1;
        div_by_zero <= dbz;
      end
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;
  localparam int W = 32;
  localparam int B = 1;
  localparam int N = W / B;
  localparam logic [W-1:0] MIN = 32'h8000_0000;

  logic         clk = 1'b0;
  logic         rst, stall, cancel, start;
  logic [2:0]   op;
  logic [W-1:0] rs, rt;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  mul_div_unit #(.DATA_WIDTH(W), .BITS_PER_CYCLE(B)) dut (
    .clk(clk), .rst(rst), .stall(stall), .cancel(cancel), .start(start),
    .op(op), .rs(rs), .rt(rt), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result of one arithmetic op, from plain integer arithmetic.
  task automatic ref_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] rh, output logic [W-1:0] rl, output bit z);
    logic [63:0] p;
    int sa, sb;
    z = 1'b0;
    sa = a;
    sb = b;
    rh = '0;
    rl = '0;
    case (o)
      3'd0: begin p = longint'(sa) * longint'(sb); rh = p[63:32]; rl = p[31:0]; end
      3'd1: begin p = {32'b0, a} * {32'b0, b}; rh = p[63:32]; rl = p[31:0]; end
      default: begin
        if (b == 0) begin
          z = 1'b1; rl = '1; rh = a;
        end else if (o == 3'd2 && a == MIN && b == '1) begin
          rl = MIN; rh = '0;
        end else if (o == 3'd2) begin
          rl = sa / sb; rh = sa % sb;
        end else begin
          rl = a / b; rh = a % b;
        end
      end
    endcase
  endtask

  // Reference model: a pending result with a count of unstalled edges left.
  int           m_rem;
  logic [W-1:0] m_hi, m_lo, p_hi, p_lo;
  bit           m_done, m_dbz, p_dbz;

  always @(posedge clk) begin
    m_done = 1'b0;
    if (rst) begin
      m_rem = 0; m_hi = '0; m_lo = '0; m_dbz = 1'b0;
    end else if (m_rem > 0) begin
      if (cancel) m_rem = 0;
      else if (!stall) begin
        m_rem--;
        if (m_rem == 0) begin
          m_hi = p_hi; m_lo = p_lo; m_done = 1'b1; m_dbz = p_dbz;
        end
      end
    end else if (start && !stall && !cancel) begin
      if (op == 3'd4) m_hi = rs;
      else if (op == 3'd5) m_lo = rs;
      else if (op < 3'd4) begin
        ref_op(op, rs, rt, p_hi, p_lo, p_dbz);
        m_rem = N + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
      check("busy", busy, m_rem > 0);
      check("done", done, m_done);
      if (m_done) check("div_by_zero", div_by_zero, m_dbz);
    end
  end

  // Called at a falling edge; returns at the falling edge after the accept edge.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1; op = o; rs = a; rt = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int stall_from, input int stall_len,
                           output int cyc, output int bcnt);
    cyc  = 0;
    bcnt = busy ? 1 : 0;
    forever begin
      stall = (cyc >= stall_from && cyc < stall_from + stall_len);
      @(negedge clk);
      cyc++;
      if (busy) bcnt++;
      if (done) break;
      if (cyc > 300) begin
        check("done_timeout", 0, 1);
        break;
      end
    end
    stall = 1'b0;
  endtask

  function automatic logic [W-1:0] rnd_val();
    logic [W-1:0] v;
    v = W'($urandom_range(15, 0));
    case ($urandom % 7)
      0: return '0;
      1: return '1;
      2: return MIN;
      3: return v;
      4: return -v - 1;
      default: return W'($urandom);
    endcase
  endfunction

  int cyc, bcnt, ndone;

  initial begin
    rst = 1'b1; stall = 1'b0; cancel = 1'b0; start = 1'b0; op = '0; rs = '0; rt = '0;
    repeat (2) @(negedge clk);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    // MULU max x max: full latency and busy window
    issue(3'd1, '1, '1);
    wait_done(-1, 0, cyc, bcnt);
    check("mulu_cycles", cyc, N + 1);
    check("mulu_busy_cycles", bcnt, N + 1);
    check("mulu_hi", hi, 32'hFFFF_FFFE);
    check("mulu_lo", lo, 32'h0000_0001);

    // MUL -7*3 then DIV -7/2 issued on the done cycle
    issue(3'd0, -32'sd7, 32'd3);
    wait_done(-1, 0, cyc, bcnt);
    check("mul_hi", hi, 32'hFFFF_FFFF);
    check("mul_lo", lo, 32'hFFFF_FFEB);
    issue(3'd2, -32'sd7, 32'd2);
    wait_done(-1, 0, cyc, bcnt);
    check("div_b2b_cycles", cyc, N + 1);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);

    // Divide by zero, then signed overflow
    issue(3'd3, 32'd100, 32'd0);
    wait_done(-1, 0, cyc, bcnt);
    check("dbz_lo", lo, 32'hFFFF_FFFF);
    check("dbz_hi", hi, 32'd100);
    check("dbz_flag", div_by_zero, 1);
    issue(3'd2, MIN, 32'hFFFF_FFFF);
    wait_done(-1, 0, cyc, bcnt);
    check("ovf_lo", lo, MIN);
    check("ovf_hi", hi, 0);
    check("ovf_flag", div_by_zero, 0);

    // DIVU with a 5-edge stall in the middle of the iterations
    issue(3'd3, 32'd1000, 32'd7);
    wait_done(10, 5, cyc, bcnt);
    check("stall_cycles", cyc, N + 1 + 5);
    check("stall_lo", lo, 32'd142);
    check("stall_hi", hi, 32'd6);

    // Start while busy is ignored; cancel after 10 iterations discards the op
    issue(3'd1, 32'hDEAD, 32'hBEEF);
    for (int i = 1; i <= 10; i++) begin
      start = (i == 4); op = 3'd4; rs = 32'hAAAA;
      @(negedge clk);
    end
    cancel = 1'b1; start = 1'b1; op = 3'd5; rs = 32'h5555;
    @(negedge clk);
    cancel = 1'b0; start = 1'b0;
    check("cancel_busy", busy, 0);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("cancel_no_done", ndone, 0);
    check("cancel_hi", hi, 32'd6);
    check("cancel_lo", lo, 32'd142);

    // MTHI/MTLO, then reset in the middle of a divide
    issue(3'd4, 32'h1234, 32'd0);
    issue(3'd5, 32'h5678, 32'd0);
    check("mthi", hi, 32'h1234);
    check("mtlo", lo, 32'h5678);
    issue(3'd2, 32'd1000, 32'd3);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst2_hi", hi, 0);
    check("rst2_lo", lo, 0);
    check("rst2_busy", busy, 0);
    check("rst2_done", done, 0);

    // Randomised traffic against the model
    ndone = 0;
    for (int c = 0; c < 4000; c++) begin
      start  = ($urandom % 3) == 0;
      op     = 3'($urandom % 8);
      rs     = rnd_val();
      rt     = rnd_val();
      stall  = ($urandom % 6) == 0;
      cancel = ($urandom % 100) == 0;
      rst    = ($urandom % 1000) == 0;
      @(negedge clk);
      if (done) ndone++;
    end
    start = 1'b0; stall = 1'b0; cancel = 1'b0; rst = 1'b0;
    repeat (60) @(negedge clk);
    if (ndone == 0) check("random_ops_completed", 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
